elm_seq: RTL and testbench



---
 rtl/elm_seq.sv | 172 +++++++++++++++++
 tb/tb_elm_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/elm_seq.sv
// Configuration sequencer for one Elm processing element: loads a small program
// over a valid/ready stream and replays it as one registered control set per cycle.
module elm_seq #(
  parameter int AddrDMEM  = 8,
  parameter int AddrCMEM  = 4,
  parameter int RptWidth  = 8,
  parameter int ConfWidth = 17 + RptWidth + 2 * AddrDMEM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ConfWidth-1:0] cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           sel_m_mux1,
  output logic [1:0]           sel_m_mux2,
  output logic                 sel_a_mux1,
  output logic [1:0]           sel_a_mux2,
  output logic                 sel_a1,
  output logic                 sel_a2,
  output logic [1:0]           sel_v_line,
  output logic [1:0]           sel_h_line,
  output logic [1:0]           sel_ram_i,
  output logic                 we_ram,
  output logic [AddrDMEM-1:0]  r_addr,
  output logic [AddrDMEM-1:0]  w_addr
);

  localparam int Depth  = 2 ** AddrCMEM;
  localparam int RptLsb = 17;
  localparam int RbLsb  = RptLsb + RptWidth;
  localparam int WbLsb  = RbLsb + AddrDMEM;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [AddrCMEM:0]     lc_reg, lc_next, lc_base, lc_last;
  logic [AddrCMEM-1:0]   pc_reg, pc_next;
  logic [RptWidth-1:0]   rep_reg, rep_next, rep_inc;
  logic [ConfWidth-1:0]  ent_reg, ent_next;
  logic                  reload_reg, reload_next;
  logic [15:0]           ctl_reg, ctl_next;
  logic [AddrDMEM-1:0]   r_addr_reg, r_addr_next, w_addr_reg, w_addr_next;
  logic                  busy_reg, busy_next, done_reg, done_next, ready_reg, ready_next;

  logic [ConfWidth-1:0]  mem [Depth];
  logic                  wr_en;
  logic [AddrCMEM-1:0]   wr_addr, rd_addr;
  logic [ConfWidth-1:0]  rd_data;

  // ready_reg is only ever high in IDLE, so it alone qualifies a write
  assign wr_en   = cfg_valid && ready_reg && !rst;
  assign lc_base = reload_reg ? '0 : lc_reg;
  assign wr_addr = lc_base[AddrCMEM-1:0];
  assign rd_addr = (state_reg == RUN) ? pc_reg + 1'b1 : '0;
  // bypass lets a word written in the start cycle be the one latched
  assign rd_data = (wr_en && wr_addr == rd_addr) ? cfg_data : mem[rd_addr];
  assign rep_inc = rep_reg + 1'b1;
  assign lc_last = lc_reg - 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= cfg_data;
  end

  always_comb begin
    state_next  = state_reg;
    lc_next     = lc_reg;
    pc_next     = pc_reg;
    rep_next    = rep_reg;
    ent_next    = ent_reg;
    reload_next = 1'b0;
    ctl_next    = '0;
    r_addr_next = '0;
    w_addr_next = '0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_en) lc_next = lc_base + 1'b1;
        if (start) begin
          busy_next = 1'b1;
          if (lc_next == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next  = RUN;
            pc_next     = '0;
            rep_next    = '0;
            ent_next    = rd_data;
            ctl_next    = rd_data[15:0];
            r_addr_next = rd_data[RbLsb +: AddrDMEM];
            w_addr_next = rd_data[WbLsb +: AddrDMEM];
          end
        end
      end
      RUN: begin
        busy_next = 1'b1;
        if (rep_reg < ent_reg[RptLsb +: RptWidth]) begin
          rep_next    = rep_inc;
          ctl_next    = ent_reg[15:0];
          r_addr_next = ent_reg[RbLsb +: AddrDMEM] + AddrDMEM'(rep_inc);
          w_addr_next = ent_reg[WbLsb +: AddrDMEM] + AddrDMEM'(rep_inc);
        end else if (ent_reg[16] || {1'b0, pc_reg} == lc_last) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          pc_next     = pc_reg + 1'b1;
          rep_next    = '0;
          ent_next    = rd_data;
          ctl_next    = rd_data[15:0];
          r_addr_next = rd_data[RbLsb +: AddrDMEM];
          w_addr_next = rd_data[WbLsb +: AddrDMEM];
        end
      end
      DONE: begin
        state_next  = IDLE;
        reload_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE) && !lc_next[AddrCMEM];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lc_reg     <= '0;
      pc_reg     <= '0;
      rep_reg    <= '0;
      ent_reg    <= '0;
      reload_reg <= 1'b0;
      ctl_reg    <= '0;
      r_addr_reg <= '0;
      w_addr_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lc_reg     <= lc_next;
      pc_reg     <= pc_next;
      rep_reg    <= rep_next;
      ent_reg    <= ent_next;
      reload_reg <= reload_next;
      ctl_reg    <= ctl_next;
      r_addr_reg <= r_addr_next;
      w_addr_reg <= w_addr_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ready_reg  <= ready_next;
    end
  end

  assign cfg_ready  = ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign sel_m_mux1 = ctl_reg[1:0];
  assign sel_m_mux2 = ctl_reg[3:2];
  assign sel_a_mux1 = ctl_reg[4];
  assign sel_a_mux2 = ctl_reg[6:5];
  assign sel_a1     = ctl_reg[7];
  assign sel_a2     = ctl_reg[8];
  assign sel_v_line = ctl_reg[10:9];
  assign sel_h_line = ctl_reg[12:11];
  assign sel_ram_i  = ctl_reg[14:13];
  assign we_ram     = ctl_reg[15];
  assign r_addr     = r_addr_reg;
  assign w_addr     = w_addr_reg;

endmodule

// File: tb/tb_elm_seq.sv
// Randomized bench for elm_seq: a queue-based program model predicts the
// per-cycle control trace, which is compared cycle by cycle against the DUT.
module tb_elm_seq;
  localparam int CW = 41;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid, cfg_ready, start, busy, done;
  logic [CW-1:0] cfg_data;
  logic [1:0] sel_m_mux1, sel_m_mux2, sel_a_mux2, sel_v_line, sel_h_line, sel_ram_i;
  logic sel_a_mux1, sel_a1, sel_a2, we_ram;
  logic [7:0] r_addr, w_addr;
  logic [15:0] ctl_obs;

  always #5 clk = ~clk;

  elm_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done),
    .sel_m_mux1(sel_m_mux1), .sel_m_mux2(sel_m_mux2), .sel_a_mux1(sel_a_mux1),
    .sel_a_mux2(sel_a_mux2), .sel_a1(sel_a1), .sel_a2(sel_a2), .sel_v_line(sel_v_line),
    .sel_h_line(sel_h_line), .sel_ram_i(sel_ram_i), .we_ram(we_ram),
    .r_addr(r_addr), .w_addr(w_addr)
  );

  assign ctl_obs = {we_ram, sel_ram_i, sel_h_line, sel_v_line, sel_a2, sel_a1,
                    sel_a_mux2, sel_a_mux1, sel_m_mux2, sel_m_mux1};

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] prog[$];
  bit first_idle = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, ctl_obs, r_addr, w_addr});
  endfunction

  function automatic logic [63:0] expv(input bit b, input bit d, input logic [15:0] c,
                                       input logic [7:0] r, input logic [7:0] w);
    return 64'({b, d, c, r, w});
  endfunction

  function automatic logic [CW-1:0] mk(input logic [15:0] ctl, input bit last, input int rpt,
                                       input int rb, input int wb);
    return {wb[7:0], rb[7:0], rpt[7:0], last, ctl};
  endfunction

  function automatic logic [CW-1:0] rnd_entry(input int maxrpt, input bit last);
    return mk(16'($urandom), last, $urandom_range(0, maxrpt), int'($urandom), int'($urandom));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    first_idle = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("reset_outs", outs(), 64'd0);
    check("reset_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    prog.delete();
    tick();
    tick();
  endtask

  // model of one offered word: a just-finished program is replaced, a full memory drops it
  task automatic offer(input logic [CW-1:0] w);
    bit rdy;
    rdy = prog.size() < 16;
    check("cfg_ready", 64'(cfg_ready), 64'(rdy));
    if (rdy) begin
      if (first_idle) prog.delete();
      prog.push_back(w);
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
  endtask

  task automatic load(input logic [CW-1:0] w);
    offer(w);
    tick();
    cfg_valid = 1'b0;
    $display("load word %h -> program size %0d", w, prog.size());
  endtask

  task automatic run(input bit with_word, input logic [CW-1:0] w, input bit noise);
    logic [15:0] ec[$];
    logic [7:0]  er[$];
    logic [7:0]  ew[$];
    logic [7:0]  rb, wb;
    if (with_word) offer(w);
    foreach (prog[i]) begin
      rb = prog[i][32:25];
      wb = prog[i][40:33];
      for (int r = 0; r <= int'(prog[i][24:17]); r++) begin
        ec.push_back(prog[i][15:0]);
        er.push_back(rb + 8'(r));
        ew.push_back(wb + 8'(r));
      end
      if (prog[i][16]) break;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    foreach (ec[k]) begin
      check($sformatf("run_cyc%0d", k), outs(), expv(1'b1, 1'b0, ec[k], er[k], ew[k]));
      if (noise) begin
        check("ready_in_run", 64'(cfg_ready), 64'd0);
        start     = 1'($urandom_range(0, 1));
        cfg_valid = 1'b1;
        cfg_data  = rnd_entry(3, 1'b0);
      end
      tick();
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    check("done_cycle", outs(), expv(1'b1, 1'b1, 16'h0, 8'h0, 8'h0));
    tick();
    check("idle_after", outs(), 64'd0);
    first_idle = 1'b1;
    $display("run of %0d entries: %0d control cycles, noise=%0d word=%0d",
             prog.size(), ec.size(), noise, with_word);
  endtask

  initial begin
    logic [CW-1:0] e;
    cfg_valid = 1'b0;
    start     = 1'b0;
    cfg_data  = '0;
    do_reset();

    // single entry with 4 repeats and DMEM writes
    load(mk(16'hA000, 1'b1, 3, 'h10, 'h20));
    run(1'b0, '0, 1'b0);

    // loading right after the run replaces the program: sel_m_mux1 1,2,2,3
    load(mk(16'h0001, 1'b0, 0, 'h00, 'h40));
    load(mk(16'h0002, 1'b0, 1, 'h08, 'h48));
    load(mk(16'h0003, 1'b1, 0, 'h10, 'h50));
    run(1'b0, '0, 1'b0);

    // address wrap
    load(mk(16'($urandom), 1'b1, 3, 'hFE, 'hFD));
    run(1'b0, '0, 1'b0);

    // 16 entries, a 17th is refused, run ends on the final entry without last
    do_reset();
    for (int i = 0; i < 16; i++) load(rnd_entry(2, 1'b0));
    load(rnd_entry(2, 1'b0));
    run(1'b0, '0, 1'b0);

    // cfg_valid and start during RUN are ignored
    do_reset();
    load(rnd_entry(3, 1'b0));
    load(rnd_entry(3, 1'b1));
    run(1'b0, '0, 1'b1);

    // word written in the start cycle is part of the program
    load(rnd_entry(2, 1'b0));
    tick();
    run(1'b1, rnd_entry(2, 1'b1), 1'b0);
    do_reset();
    run(1'b1, rnd_entry(2, 1'b0), 1'b0);

    // reset in the second RUN cycle, then an empty-program start
    do_reset();
    e = mk(16'($urandom) | 16'h8000, 1'b1, 5, int'($urandom), int'($urandom));
    load(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_run1", outs(), expv(1'b1, 1'b0, e[15:0], e[32:25], e[40:33]));
    tick();
    check("rst_run2", outs(), expv(1'b1, 1'b0, e[15:0], e[32:25] + 8'd1, e[40:33] + 8'd1));
    rst = 1'b1;
    tick();
    check("rst_mid_outs", outs(), 64'd0);
    check("rst_mid_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    prog.delete();
    run(1'b0, '0, 1'b0);

    // random programs, sometimes appended to the previous one
    for (int round = 0; round < 10; round++) begin
      int n;
      if ($urandom_range(0, 3) == 0) tick();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) load(rnd_entry(3, $urandom_range(0, 3) == 0));
      run($urandom_range(0, 2) == 0, rnd_entry(3, 1'b0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
